// File: rtl/me_best_mv_select_if.sv
// Purpose: bundles the SAD-tree candidate bus and the best-MV result bus of me_best_mv_select.
// Latency: none (wires only); results change one cycle after the accepted candidate.
// Backpressure: none; the consumer accepts one candidate per cycle unconditionally.
// Ports: start/sad_valid/sad_last/cand_mv/SAD* flow master->slave;
//        busy/done/cand_cnt/best_sad*/best_mv* flow slave->master.
interface me_best_mv_select_if #(
  parameter int MV_W  = 7,
  parameter int CNT_W = 12
);
  logic                  start;
  logic                  sad_valid;
  logic                  sad_last;
  logic [2*MV_W-1:0]     cand_mv;
  logic [17:0]           SAD32x32;
  logic [63:0]           SAD16x16;
  logic [119:0]          SAD16x8;
  logic [119:0]          SAD8x16;
  logic [223:0]          SAD8x8;

  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      cand_cnt;
  logic [17:0]           best_sad32x32;
  logic [63:0]           best_sad16x16;
  logic [119:0]          best_sad16x8;
  logic [119:0]          best_sad8x16;
  logic [223:0]          best_sad8x8;
  logic [2*MV_W-1:0]     best_mv32x32;
  logic [8*MV_W-1:0]     best_mv16x16;
  logic [16*MV_W-1:0]    best_mv16x8;
  logic [16*MV_W-1:0]    best_mv8x16;
  logic [32*MV_W-1:0]    best_mv8x8;

  modport master (
    output start, sad_valid, sad_last, cand_mv,
           SAD32x32, SAD16x16, SAD16x8, SAD8x16, SAD8x8,
    input  busy, done, cand_cnt,
           best_sad32x32, best_sad16x16, best_sad16x8, best_sad8x16, best_sad8x8,
           best_mv32x32, best_mv16x16, best_mv16x8, best_mv8x16, best_mv8x8
  );

  modport slave (
    input  start, sad_valid, sad_last, cand_mv,
           SAD32x32, SAD16x16, SAD16x8, SAD8x16, SAD8x8,
    output busy, done, cand_cnt,
           best_sad32x32, best_sad16x16, best_sad16x8, best_sad8x16, best_sad8x8,
           best_mv32x32, best_mv16x16, best_mv16x8, best_mv8x16, best_mv8x8
  );
endinterface

// File: rtl/me_best_mv_select.sv
// Purpose: tracks the minimum SAD and its MV for all 37 partitions of a 32x32 integer-ME search.
// Latency: best_* reflect a candidate one cycle after it is accepted; done pulses the cycle after sad_last.
// Backpressure: none; one candidate per cycle, inputs used unregistered.
// Ports: clk, rst (sync, active-high); bus (slave modport of me_best_mv_select_if) carries
//        start/sad_valid/sad_last/cand_mv/SAD* in and busy/done/cand_cnt/best_sad*/best_mv* out.
module me_best_mv_select #(
  parameter int MV_W  = 7,
  parameter int CNT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  me_best_mv_select_if.slave   bus
);

  localparam int MVP = 2 * MV_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t              state;
  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [17:0]         s32_q;
  logic [63:0]         s16_q;
  logic [119:0]        s168_q;
  logic [119:0]        s816_q;
  logic [223:0]        s88_q;
  logic [MVP-1:0]      m32_q;
  logic [4*MVP-1:0]    m16_q;
  logic [8*MVP-1:0]    m168_q;
  logic [8*MVP-1:0]    m816_q;
  logic [16*MVP-1:0]   m88_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      s32_q  <= '0;
      s16_q  <= '0;
      s168_q <= '0;
      s816_q <= '0;
      s88_q  <= '0;
      m32_q  <= '0;
      m16_q  <= '0;
      m168_q <= '0;
      m816_q <= '0;
      m88_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        // Start wins in every state and discards any candidate presented with it.
        // Bests seed at all-ones so an all-ones SAD can never win.
        state  <= SEARCH;
        busy_q <= 1'b1;
        cnt_q  <= '0;
        s32_q  <= '1;
        s16_q  <= '1;
        s168_q <= '1;
        s816_q <= '1;
        s88_q  <= '1;
        m32_q  <= '0;
        m16_q  <= '0;
        m168_q <= '0;
        m816_q <= '0;
        m88_q  <= '0;
      end else begin
        case (state)
          IDLE: begin
          end
          SEARCH: begin
            if (bus.sad_valid) begin
              // Strict less-than keeps the earliest candidate on ties.
              if (bus.SAD32x32 < s32_q) begin
                s32_q <= bus.SAD32x32;
                m32_q <= bus.cand_mv;
              end
              for (int k = 0; k < 4; k++) begin
                if (bus.SAD16x16[16*k +: 16] < s16_q[16*k +: 16]) begin
                  s16_q[16*k +: 16]  <= bus.SAD16x16[16*k +: 16];
                  m16_q[MVP*k +: MVP] <= bus.cand_mv;
                end
              end
              for (int k = 0; k < 8; k++) begin
                if (bus.SAD16x8[15*k +: 15] < s168_q[15*k +: 15]) begin
                  s168_q[15*k +: 15]   <= bus.SAD16x8[15*k +: 15];
                  m168_q[MVP*k +: MVP] <= bus.cand_mv;
                end
                if (bus.SAD8x16[15*k +: 15] < s816_q[15*k +: 15]) begin
                  s816_q[15*k +: 15]   <= bus.SAD8x16[15*k +: 15];
                  m816_q[MVP*k +: MVP] <= bus.cand_mv;
                end
              end
              for (int k = 0; k < 16; k++) begin
                if (bus.SAD8x8[14*k +: 14] < s88_q[14*k +: 14]) begin
                  s88_q[14*k +: 14]   <= bus.SAD8x8[14*k +: 14];
                  m88_q[MVP*k +: MVP] <= bus.cand_mv;
                end
              end
              if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_ONE;
              end
              if (bus.sad_last) begin
                state  <= DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.cand_cnt      = cnt_q;
  assign bus.best_sad32x32 = s32_q;
  assign bus.best_sad16x16 = s16_q;
  assign bus.best_sad16x8  = s168_q;
  assign bus.best_sad8x16  = s816_q;
  assign bus.best_sad8x8   = s88_q;
  assign bus.best_mv32x32  = m32_q;
  assign bus.best_mv16x16  = m16_q;
  assign bus.best_mv16x8   = m168_q;
  assign bus.best_mv8x16   = m816_q;
  assign bus.best_mv8x8    = m88_q;

endmodule

// File: tb/tb_me_best_mv_select.sv
// Purpose: self-checking bench for me_best_mv_select with a partition-array reference model.
// Latency: model is updated at each rising edge; DUT is sampled on falling edges.
// Backpressure: none to model; stimulus is one candidate per cycle at most.
module tb_me_best_mv_select;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  me_best_mv_select_if #(.MV_W(7), .CNT_W(12)) bus ();

  me_best_mv_select #(.MV_W(7), .CNT_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [11:0]  cnt;
    logic [17:0]  s32;
    logic [63:0]  s16;
    logic [119:0] s168;
    logic [119:0] s816;
    logic [223:0] s88;
    logic [13:0]  m32;
    logic [55:0]  m16;
    logic [111:0] m168;
    logic [111:0] m816;
    logic [223:0] m88;
  } res_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: partition 0 = 32x32, 1..4 = 16x16, 5..12 = 16x8, 13..20 = 8x16, 21..36 = 8x8.
  int unsigned m_sad [37];
  logic [13:0] m_mv  [37];
  int unsigned m_cnt = 0;
  bit          m_search = 1'b0;
  res_t        exp_q [$];

  int unsigned cur_sad [37];
  logic [13:0] cur_mv;

  function automatic int pw(int p);
    if (p == 0) return 18;
    if (p < 5)  return 16;
    if (p < 21) return 15;
    return 14;
  endfunction

  function automatic int unsigned pmax(int p);
    return (32'd1 << pw(p)) - 32'd1;
  endfunction

  function automatic logic [13:0] mvp(int x, int y);
    return {7'(y), 7'(x)};
  endfunction

  function automatic res_t model_res();
    res_t r;
    r.cnt = 12'(m_cnt);
    r.s32 = 18'(m_sad[0]);
    r.m32 = m_mv[0];
    for (int k = 0; k < 4; k++) begin
      r.s16[16*k +: 16] = 16'(m_sad[1+k]);
      r.m16[14*k +: 14] = m_mv[1+k];
    end
    for (int k = 0; k < 8; k++) begin
      r.s168[15*k +: 15] = 15'(m_sad[5+k]);
      r.m168[14*k +: 14] = m_mv[5+k];
      r.s816[15*k +: 15] = 15'(m_sad[13+k]);
      r.m816[14*k +: 14] = m_mv[13+k];
    end
    for (int k = 0; k < 16; k++) begin
      r.s88[14*k +: 14] = 14'(m_sad[21+k]);
      r.m88[14*k +: 14] = m_mv[21+k];
    end
    return r;
  endfunction

  function automatic res_t dut_res();
    return {bus.cand_cnt, bus.best_sad32x32, bus.best_sad16x16, bus.best_sad16x8,
            bus.best_sad8x16, bus.best_sad8x8, bus.best_mv32x32, bus.best_mv16x16,
            bus.best_mv16x8, bus.best_mv8x16, bus.best_mv8x8};
  endfunction

  task automatic cmp(string nm, logic [255:0] a, logic [255:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic cmp_res(string tag, res_t a, res_t e);
    cmp({tag, ".cand_cnt"}, 256'(a.cnt),  256'(e.cnt));
    cmp({tag, ".sad32x32"}, 256'(a.s32),  256'(e.s32));
    cmp({tag, ".sad16x16"}, 256'(a.s16),  256'(e.s16));
    cmp({tag, ".sad16x8"},  256'(a.s168), 256'(e.s168));
    cmp({tag, ".sad8x16"},  256'(a.s816), 256'(e.s816));
    cmp({tag, ".sad8x8"},   256'(a.s88),  256'(e.s88));
    cmp({tag, ".mv32x32"},  256'(a.m32),  256'(e.m32));
    cmp({tag, ".mv16x16"},  256'(a.m16),  256'(e.m16));
    cmp({tag, ".mv16x8"},   256'(a.m168), 256'(e.m168));
    cmp({tag, ".mv8x16"},   256'(a.m816), 256'(e.m816));
    cmp({tag, ".mv8x8"},    256'(a.m88),  256'(e.m88));
  endtask

  // Behavioural effect of one rising edge on the tracked minima.
  task automatic model_edge(bit st, bit v, bit l, bit r);
    if (r) begin
      m_search = 1'b0;
      m_cnt    = 0;
      for (int p = 0; p < 37; p++) begin
        m_sad[p] = 0;
        m_mv[p]  = '0;
      end
    end else if (st) begin
      m_search = 1'b1;
      m_cnt    = 0;
      for (int p = 0; p < 37; p++) begin
        m_sad[p] = pmax(p);
        m_mv[p]  = '0;
      end
    end else if (m_search && v) begin
      for (int p = 0; p < 37; p++) begin
        if (cur_sad[p] < m_sad[p]) begin
          m_sad[p] = cur_sad[p];
          m_mv[p]  = cur_mv;
        end
      end
      if (m_cnt < 4095) m_cnt++;
      if (l) begin
        m_search = 1'b0;
        exp_q.push_back(model_res());
      end
    end
  endtask

  task automatic step(bit st, bit v, bit l, bit r);
    rst           = r;
    bus.start     = st;
    bus.sad_valid = v;
    bus.sad_last  = l;
    bus.cand_mv   = cur_mv;
    bus.SAD32x32  = 18'(cur_sad[0]);
    for (int k = 0; k < 4; k++)  bus.SAD16x16[16*k +: 16] = 16'(cur_sad[1+k]);
    for (int k = 0; k < 8; k++)  bus.SAD16x8[15*k +: 15]  = 15'(cur_sad[5+k]);
    for (int k = 0; k < 8; k++)  bus.SAD8x16[15*k +: 15]  = 15'(cur_sad[13+k]);
    for (int k = 0; k < 16; k++) bus.SAD8x8[14*k +: 14]   = 14'(cur_sad[21+k]);
    @(posedge clk);
    model_edge(st, v, l, r);
    #1;
  endtask

  task automatic set_all(int unsigned val);
    for (int p = 0; p < 37; p++) cur_sad[p] = val & pmax(p);
  endtask

  // Mix of small values (frequent ties), all-ones (never wins) and full-range values.
  task automatic rand_cand();
    for (int p = 0; p < 37; p++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      cur_sad[p] = pmax(p);
      else if (sel < 5)  cur_sad[p] = $urandom_range(0, 15);
      else               cur_sad[p] = $urandom & pmax(p);
    end
    cur_mv = {7'($urandom), 7'($urandom)};
  endtask

  // Monitor: per-cycle status against the model, results popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cmp("busy",     256'(bus.busy),     256'(m_search));
      cmp("done",     256'(bus.done),     256'(exp_q.size() != 0));
      cmp("cand_cnt", 256'(bus.cand_cnt), 256'(m_cnt));
      if (exp_q.size() != 0) cmp_res("done_result", dut_res(), exp_q.pop_front());
    end
  end

  initial begin
    cur_mv = mvp(9, 9);
    set_all(123);

    // Reset held two cycles with junk candidates present.
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 0);
    cmp("reset_busy", 256'(bus.busy), 256'(0));
    cmp("reset_done", 256'(bus.done), 256'(0));
    cmp_res("reset", dut_res(), '0);

    // Basic minimum on 32x32.
    set_all(200);
    step(1, 1, 0, 0);
    cmp("start_busy", 256'(bus.busy), 256'(1));
    cur_sad[0] = 100; cur_mv = mvp(1, 0);   step(0, 1, 0, 0);
    cur_sad[0] = 50;  cur_mv = mvp(-2, 3);  step(0, 1, 0, 0);
    cur_sad[0] = 70;  cur_mv = mvp(4, -4);  step(0, 1, 1, 0);
    cmp("basic_done",  256'(bus.done),          256'(1));
    cmp("basic_busy",  256'(bus.busy),          256'(0));
    cmp("basic_sad",   256'(bus.best_sad32x32), 256'(50));
    cmp("basic_mv",    256'(bus.best_mv32x32),  256'(mvp(-2, 3)));
    cmp("basic_cnt",   256'(bus.cand_cnt),      256'(3));
    step(0, 0, 0, 0);
    cmp("basic_done_pulse", 256'(bus.done), 256'(0));

    // Tie: earliest candidate wins everywhere.
    step(1, 0, 0, 0);
    set_all(40); cur_mv = mvp(5, 5); step(0, 1, 0, 0);
    cur_mv = mvp(6, 6);              step(0, 1, 1, 0);
    cmp("tie_mv8x8_15", 256'(bus.best_mv8x8[14*15 +: 14]), 256'(mvp(5, 5)));

    // Independence of 8x8 partitions.
    step(1, 0, 0, 0);
    set_all(20); cur_sad[21+5] = 90; cur_mv = mvp(0, 1); step(0, 1, 0, 0);
    set_all(60); cur_sad[21+5] = 10; cur_mv = mvp(0, 2); step(0, 1, 1, 0);
    cmp("indep_mv5",  256'(bus.best_mv8x8[14*5 +: 14]),  256'(mvp(0, 2)));
    cmp("indep_sad5", 256'(bus.best_sad8x8[14*5 +: 14]), 256'(10));
    cmp("indep_mv0",  256'(bus.best_mv8x8[0 +: 14]),     256'(mvp(0, 1)));
    cmp("indep_sad0", 256'(bus.best_sad8x8[0 +: 14]),    256'(20));

    // Restart mid-search discards the first pass.
    set_all(300);
    step(1, 0, 0, 0);
    cur_sad[0] = 5;  step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    cur_sad[0] = 30; step(0, 1, 1, 0);
    cmp("restart_sad", 256'(bus.best_sad32x32), 256'(30));
    cmp("restart_cnt", 256'(bus.cand_cnt),      256'(1));
    step(0, 0, 0, 0);

    // Reset in the middle of a search.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin rand_cand(); step(0, 1, 0, 0); end
    step(0, 0, 0, 1);
    rand_cand(); step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    cmp("rst_mid_busy", 256'(bus.busy), 256'(0));
    cmp("rst_mid_done", 256'(bus.done), 256'(0));
    cmp_res("rst_mid", dut_res(), '0);

    // Counter saturation.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4100; i++) begin
      set_all(4200 - i); cur_mv = {7'(i), 7'(i >> 7)}; step(0, 1, 0, 0);
    end
    step(0, 1, 1, 0);
    cmp("sat_cnt", 256'(bus.cand_cnt), 256'(4095));
    step(0, 0, 0, 0);

    // Randomized searches with gaps, stray sad_last, idle junk and occasional restarts.
    for (int s = 0; s < 30; s++) begin
      int n;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        rand_cand(); step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end
      cmp_res("hold", dut_res(), model_res());
      rand_cand();
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          rand_cand(); step(0, 0, 1'($urandom_range(0, 1)), 0);
        end
        if ($urandom_range(0, 29) == 0) begin
          rand_cand(); step(1, 1, 0, 0);
        end
        rand_cand();
        step(0, 1, (i == n - 1), 0);
      end
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    cmp("scoreboard_empty", 256'(exp_q.size()), 256'(0));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
